// File: rtl/cache_adapter_pkg.sv
// Shared types and size helpers for the cache line <-> memory beat adapter.
package cache_adapter_pkg;

  typedef enum logic [1:0] {
    OP_NONE       = 2'b00,
    OP_FILL       = 2'b01,
    OP_EVICT      = 2'b10,
    OP_EVICT_FILL = 2'b11
  } adapter_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_RD,
    S_DONE
  } adapter_state_t;

  function automatic int beats(input int line_bits, input int word_bits);
    return line_bits / word_bits;
  endfunction

  function automatic int off_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/line_beat_sequencer.sv
// Beat counter for one burst phase: counts acked beats from a reloadable start word.
// The word index wraps modulo BEATS, which gives critical-word-first ordering for free.
module line_beat_sequencer
  #(parameter int BEATS = 8,
    parameter int BW    = $clog2(BEATS))
  (input  logic          CLK,
   input  logic          RST,
   input  logic          load,
   input  logic [BW-1:0] start,
   input  logic          advance,
   output logic [BW-1:0] word,
   output logic          last);

  logic [BW-1:0] count;
  logic [BW-1:0] base;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      base  <= '0;
    end else if (load) begin
      count <= '0;
      base  <= start;
    end else if (advance) begin
      count <= count + 1'b1;
    end
  end

  assign word = base + count;
  assign last = (count == BW'(BEATS - 1));

endmodule

// File: rtl/cache_line_burst_adapter.sv
// Cache line <-> word-wide memory adapter: evicts a line as beats, refills a line from beats.
// Build option CRITICAL_WORD_FIRST_EN: refill starts at the requested word and adds crit_valid.
module cache_line_burst_adapter
  import cache_adapter_pkg::*;
  #(parameter int LINE_BITS = 256,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 32)
  (input  logic                 CLK,
   input  logic                 RST,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [ADDR_BITS-1:0] evict_addr,
   input  logic [LINE_BITS-1:0] evict_line,
   output logic [LINE_BITS-1:0] fill_line,
   output logic                 done,
`ifdef CRITICAL_WORD_FIRST_EN
   output logic                 crit_valid,
`endif
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [WORD_BITS-1:0] mem_wdata,
   input  logic [WORD_BITS-1:0] mem_rdata,
   input  logic                 mem_ack);

  localparam int BEATS = beats(LINE_BITS, WORD_BITS);
  localparam int BW    = $clog2(BEATS);
  localparam int OFF   = off_bits(LINE_BITS);
  localparam int WB    = $clog2(WORD_BITS / 8);
  localparam logic [ADDR_BITS-1:0] LINE_MASK = ~(ADDR_BITS'(LINE_BITS / 8) - 1'b1);

  // Line base of 'base' with the beat's word index placed in the offset field.
  function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [ADDR_BITS-1:0] base,
                                                     input logic [BW-1:0]        idx);
    return (base & LINE_MASK) | (ADDR_BITS'(idx) << WB);
  endfunction

  adapter_state_t         state;
  adapter_op_t            op_q;
  logic [ADDR_BITS-1:0]   fill_addr_q;
  logic [ADDR_BITS-1:0]   evict_addr_q;
  logic [LINE_BITS-1:0]   evict_q;
  logic                   phase_end;

  logic                   accept;
  logic                   ack;
  logic [BW-1:0]          req_crit;
  logic [BW-1:0]          fill_crit;
  logic                   seq_load;
  logic [BW-1:0]          seq_start;
  logic [BW-1:0]          seq_word;
  logic                   seq_last;

  assign accept = req_valid & req_ready & (req_op != 2'b00);
  assign ack    = mem_req & mem_ack;

`ifdef CRITICAL_WORD_FIRST_EN
  assign req_crit  = req_addr[OFF-1:WB];
  assign fill_crit = fill_addr_q[OFF-1:WB];
`else
  assign req_crit  = '0;
  assign fill_crit = '0;
`endif

  // Evictions always start at word 0; a refill loads its start word on acceptance or in the gap.
  assign seq_load  = accept | (state == S_GAP);
  assign seq_start = (state == S_IDLE) ? ((req_op == 2'b01) ? req_crit : '0) : fill_crit;

  line_beat_sequencer #(.BEATS(BEATS), .BW(BW)) u_seq (
    .CLK     (CLK),
    .RST     (RST),
    .load    (seq_load),
    .start   (seq_start),
    .advance (ack),
    .word    (seq_word),
    .last    (seq_last)
  );

  // Each beat is registered, held until ack, and the next one is issued the cycle after.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      op_q         <= OP_NONE;
      fill_addr_q  <= '0;
      evict_addr_q <= '0;
      evict_q      <= '0;
      phase_end    <= 1'b0;
      req_ready    <= 1'b1;
      done         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      fill_line    <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_valid   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_valid <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q         <= adapter_op_t'(req_op);
            fill_addr_q  <= req_addr;
            evict_addr_q <= evict_addr;
            evict_q      <= evict_line;
            phase_end    <= 1'b0;
            req_ready    <= 1'b0;
            mem_req      <= 1'b1;
            if (req_op == 2'b01) begin
              state     <= S_RD;
              mem_we    <= 1'b0;
              mem_addr  <= beat_addr(req_addr, seq_start);
              fill_line <= '0;
            end else begin
              state     <= S_WR;
              mem_we    <= 1'b1;
              mem_addr  <= beat_addr(evict_addr, '0);
              mem_wdata <= evict_line[WORD_BITS-1:0];
            end
          end
        end
        S_WR, S_RD: begin
          if (mem_req) begin
            if (mem_ack) begin
              mem_req   <= 1'b0;
              phase_end <= seq_last;
              if (state == S_RD) begin
                fill_line[int'(seq_word)*WORD_BITS +: WORD_BITS] <= mem_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
                crit_valid <= (seq_word == fill_crit);
`endif
              end
            end
          end else if (phase_end) begin
            phase_end <= 1'b0;
            if (state == S_WR && op_q == OP_EVICT_FILL) begin
              state     <= S_GAP;
              mem_we    <= 1'b0;
              fill_line <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            mem_req <= 1'b1;
            if (state == S_WR) begin
              mem_addr  <= beat_addr(evict_addr_q, seq_word);
              mem_wdata <= evict_q[int'(seq_word)*WORD_BITS +: WORD_BITS];
            end else begin
              mem_addr  <= beat_addr(fill_addr_q, seq_word);
            end
          end
        end
        S_GAP: begin
          state    <= S_RD;
          mem_req  <= 1'b1;
          mem_addr <= beat_addr(fill_addr_q, seq_start);
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_burst_adapter.sv
// Self-checking bench for cache_line_burst_adapter (default 256b line / 32b word).
// Works in either build; crit_valid is checked only when CRITICAL_WORD_FIRST_EN is defined.
module tb_cache_line_burst_adapter;

  localparam int LINE_BITS  = 256;
  localparam int WORD_BITS  = 32;
  localparam int ADDR_BITS  = 32;
  localparam int BEATS      = LINE_BITS / WORD_BITS;
  localparam int WORD_BYTES = WORD_BITS / 8;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [ADDR_BITS-1:0] req_addr;
  logic [ADDR_BITS-1:0] evict_addr;
  logic [LINE_BITS-1:0] evict_line;
  logic [LINE_BITS-1:0] fill_line;
  logic                 done;
`ifdef CRITICAL_WORD_FIRST_EN
  logic                 crit_valid;
`endif
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_BITS-1:0] mem_wdata;
  logic [WORD_BITS-1:0] mem_rdata;
  logic                 mem_ack;

  always #5 CLK = ~CLK;

  cache_line_burst_adapter #(.LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS), .ADDR_BITS(ADDR_BITS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .evict_addr (evict_addr),
    .evict_line (evict_line),
    .fill_line  (fill_line),
    .done       (done),
`ifdef CRITICAL_WORD_FIRST_EN
    .crit_valid (crit_valid),
`endif
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return ({a[15:0], a[31:16]} ^ 32'h5A3C_96E1) + (a * 32'h9E37_79B1);
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t seen[$];
  int    total = 0;
  int    bad   = 0;
  bit    tie_ack = 1'b1;
  int    wait_cnt = 0;
  logic [LINE_BITS-1:0] model_fill = '0;

  // Memory responder plus beat log; a beat is logged when req and ack both stand before the edge.
  always @(negedge CLK) begin
    if (tie_ack) begin
      mem_ack = 1'b1;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = $urandom_range(0, 3);
    end else if (mem_req) begin
      if (wait_cnt == 0) mem_ack = 1'b1;
      else wait_cnt--;
    end
    if (mem_req && mem_ack && !RST) seen.push_back('{mem_we, mem_addr, mem_wdata});
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*WORD_BITS +: WORD_BITS] = $urandom;
    return l;
  endfunction

  function automatic int lat_for(input logic [1:0] op);
    return (op == 2'b11) ? 4*BEATS + 2 : 2*BEATS + 1;
  endfunction

  // Issues one request and watches it to completion; evict_line is scrambled right after acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] raddr, input logic [31:0] eaddr,
                               input logic [LINE_BITS-1:0] line, output int lat, output int dones,
                               output int crits, output logic ready_first);
    lat = -1; dones = 0; crits = 0; ready_first = 1'bx;
    @(negedge CLK);
    req_valid = 1'b1; req_op = op; req_addr = raddr; evict_addr = eaddr; evict_line = line;
    for (int n = 1; n <= 400; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        req_valid   = 1'b0;
        req_op      = 2'b00;
        evict_line  = ~line ^ rand_line();
        ready_first = req_ready;
      end
      if (done) begin
        dones++;
        if (lat < 0) lat = n;
      end
`ifdef CRITICAL_WORD_FIRST_EN
      if (crit_valid) crits++;
`endif
      if (lat >= 0 && n >= lat + 3) break;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] raddr,
                       input logic [31:0] eaddr, input bit tie, input int exp_lat);
    logic [LINE_BITS-1:0] line;
    logic [31:0] e_addr[$];
    logic [31:0] e_data[$];
    logic        e_we[$];
    int lat, dones, crits, crit;
    logic ready_first;
    line = rand_line();
    crit = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    crit = int'(raddr[4:2]);
`endif
    if (op[1]) begin
      for (int i = 0; i < BEATS; i++) begin
        e_addr.push_back((eaddr & LINE_MASK) + 32'(i * WORD_BYTES));
        e_we.push_back(1'b1);
        e_data.push_back(line[i*WORD_BITS +: WORD_BITS]);
      end
    end
    if (op[0]) begin
      for (int k = 0; k < BEATS; k++) begin
        e_addr.push_back((raddr & LINE_MASK) + 32'(((crit + k) % BEATS) * WORD_BYTES));
        e_we.push_back(1'b0);
        e_data.push_back(32'h0);
      end
      for (int j = 0; j < BEATS; j++)
        model_fill[j*WORD_BITS +: WORD_BITS] = mem_fn((raddr & LINE_MASK) + 32'(j * WORD_BYTES));
    end
    tie_ack = tie;
    seen.delete();
    applyStimulus(op, raddr, eaddr, line, lat, dones, crits, ready_first);
    checkOutput({tag, " ready drop"}, ready_first, 1'b0);
    checkOutput({tag, " beat count"}, seen.size(), e_addr.size());
    for (int i = 0; i < seen.size() && i < e_addr.size(); i++) begin
      checkOutput($sformatf("%s beat%0d addr", tag, i), seen[i].addr, e_addr[i]);
      checkOutput($sformatf("%s beat%0d we", tag, i), seen[i].we, e_we[i]);
      if (e_we[i]) checkOutput($sformatf("%s beat%0d wdata", tag, i), seen[i].wdata, e_data[i]);
    end
    checkOutput({tag, " fill_line"}, fill_line, model_fill);
    checkOutput({tag, " done pulses"}, dones, 1);
    if (exp_lat >= 0) checkOutput({tag, " latency"}, lat, exp_lat);
    else checkOutput({tag, " completed"}, lat > 0, 1'b1);
    checkOutput({tag, " ready after"}, req_ready, 1'b1);
`ifdef CRITICAL_WORD_FIRST_EN
    checkOutput({tag, " crit pulses"}, crits, op[0] ? 1 : 0);
`endif
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] raddr;
    logic [31:0] eaddr;
    bit          tie;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; evict_addr = '0; evict_line = '0;
    mem_ack = 1'b0;
    vecs[0] = '{2'b01, 32'h1000_0014, 32'h0000_0000, 1'b1, 17};
    vecs[1] = '{2'b10, 32'h0000_0000, 32'h2000_0040, 1'b1, 17};
    vecs[2] = '{2'b11, 32'h3000_0000, 32'h2000_0040, 1'b0, -1};
    vecs[3] = '{2'b11, 32'h3000_0008, 32'h2000_00A4, 1'b1, 34};
    vecs[4] = '{2'b01, 32'h1000_003C, 32'h0000_0000, 1'b0, -1};
    vecs[5] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 17};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    checkOutput("reset req_ready", req_ready, 1'b1);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset mem_req", mem_req, 1'b0);
    checkOutput("reset mem_we", mem_we, 1'b0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset fill_line", fill_line, '0);

    for (int v = 0; v < 6; v++)
      runOp($sformatf("vec%0d", v), vecs[v].op, vecs[v].raddr, vecs[v].eaddr, vecs[v].tie, vecs[v].lat);

    for (int r = 0; r < 12; r++) begin
      logic [1:0] op;
      bit tie;
      op  = 2'($urandom_range(1, 3));
      tie = 1'($urandom_range(0, 1));
      runOp($sformatf("rnd%0d", r), op, $urandom, $urandom, tie, tie ? lat_for(op) : -1);
    end

    // Dropped no-op request with ack standing while idle.
    tie_ack = 1'b1;
    seen.delete();
    @(negedge CLK);
    req_valid = 1'b1; req_op = 2'b00;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      checkOutput($sformatf("noop c%0d mem_req", n), mem_req, 1'b0);
      checkOutput($sformatf("noop c%0d done", n), done, 1'b0);
      checkOutput($sformatf("noop c%0d ready", n), req_ready, 1'b1);
    end
    req_valid = 1'b0;
    checkOutput("noop beats", seen.size(), 0);

    // Reset while read beat 3 is on the bus.
    @(negedge CLK);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h1000_0020;
    for (int n = 1; n <= 7; n++) begin
      @(negedge CLK);
      if (n == 1) begin req_valid = 1'b0; req_op = 2'b00; end
    end
    checkOutput("rst beat3 mem_req", mem_req, 1'b1);
    checkOutput("rst beat3 mem_addr", mem_addr, 32'h1000_002C
`ifdef CRITICAL_WORD_FIRST_EN
                - 32'h0000_000C + 32'h0000_000C
`endif
                );
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("rst mem_req", mem_req, 1'b0);
    checkOutput("rst req_ready", req_ready, 1'b1);
    checkOutput("rst done", done, 1'b0);
    checkOutput("rst fill_line", fill_line, '0);
    checkOutput("rst mem_addr", mem_addr, 32'h0);
    RST = 1'b0;
    model_fill = '0;
    seen.delete();
    runOp("after_rst", 2'b01, 32'h1000_0014, 32'h0, 1'b1, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
